// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle over 32 cycles.
module muldiv_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_t;

    state_t      state, state_next;
    logic [4:0]  count;
    logic [63:0] acc;        // product, or remainder in acc[32:0] for divide
    logic [31:0] ra;         // multiplicand, or dividend shifting into quotient
    logic [31:0] rb;         // multiplier shifting right, or divisor
    logic        is_div;
    logic        sign_a, sign_b;
    logic        div_zero;

    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic [32:0] rem_diff;
    logic        rem_ge;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic        arith_req;

    assign busy      = (state != IDLE);
    assign arith_req = start && !op[2];

    assign mul_sum  = {1'b0, acc[63:32]} + {1'b0, (rb[0] ? ra : 32'd0)};
    assign rem_sh   = {acc[31:0], ra[31]};
    assign rem_diff = rem_sh - {1'b0, rb};
    assign rem_ge   = (rem_sh >= {1'b0, rb});

    assign prod_fix = (sign_a ^ sign_b) ? (~acc + 64'd1) : acc;
    assign quot_fix = (sign_a ^ sign_b) ? (~ra + 32'd1) : ra;
    assign rem_fix  = sign_a ? (~acc[31:0] + 32'd1) : acc[31:0];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (arith_req) state_next = CALC;
            CALC:    if (count == 5'd31) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            acc      <= '0;
            ra       <= '0;
            rb       <= '0;
            is_div   <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                // Signed ops run on magnitudes; signs restored in FINISH
                                sign_a   <= !op[0] && operand_a[31];
                                sign_b   <= !op[0] && operand_b[31];
                                ra       <= (!op[0] && operand_a[31]) ? (~operand_a + 32'd1) : operand_a;
                                rb       <= (!op[0] && operand_b[31]) ? (~operand_b + 32'd1) : operand_b;
                                is_div   <= op[1];
                                div_zero <= (operand_b == 32'd0);
                                acc      <= '0;
                                count    <= '0;
                            end
                            OP_MTHI: begin
                                hi   <= operand_a;
                                done <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo   <= operand_a;
                                done <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    count <= count + 5'd1;
                    if (is_div) begin
                        acc <= {31'd0, (rem_ge ? rem_diff : rem_sh)};
                        ra  <= {ra[30:0], rem_ge};
                    end else begin
                        acc <= {mul_sum, acc[31:1]};
                        rb  <= {1'b0, rb[31:1]};
                    end
                end
                FINISH: begin
                    done <= 1'b1;
                    if (is_div) begin
                        // Quotient sign fix would corrupt the all-ones divide-by-zero result
                        lo <= div_zero ? '1 : quot_fix;
                        hi <= rem_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
